// File: rtl/riscv_cpu_pkg.sv
// riscv_cpu_pkg
// Shared constants and types for the core's data-memory path.
//   DATA_WIDTH    : data bus width (32 only)
//   dmem_state_e  : data_mem_adapter FSM states (IDLE, read-modify-write write phase)
package riscv_cpu_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic {
        DMEM_IDLE   = 1'b0,
        DMEM_RMW_WR = 1'b1
    } dmem_state_e;

endpackage

// File: rtl/dmem_byte_merge.sv
// dmem_byte_merge
// Combinational byte-lane merge used by the read-modify-write path of
// data_mem_adapter. Only present when DATA_MEM_RMW_EN is defined.
// Ports:
//   old_word_i : word read back from the SRAM
//   new_word_i : lane-aligned store data
//   be_i       : byte enables of the store (1 = take new byte)
//   merged_o   : word to write back
`ifdef DATA_MEM_RMW_EN
module dmem_byte_merge
    import riscv_cpu_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] old_word_i,
    input  logic [DATA_WIDTH-1:0] new_word_i,
    input  logic [3:0]            be_i,
    output logic [DATA_WIDTH-1:0] merged_o
);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign merged_o[8*gi +: 8] = be_i[gi] ? new_word_i[8*gi +: 8]
                                                  : old_word_i[8*gi +: 8];
        end
    endgenerate

endmodule
`endif

// File: rtl/data_mem_adapter.sv
// data_mem_adapter
// Bridges the load/store unit's req/gnt/rvalid data interface to a
// single-port synchronous SRAM with one-cycle read latency.
// Configuration macro: DATA_MEM_RMW_EN
//   defined   : SRAM has no byte enables; sub-word stores are done as a
//               read (grant cycle) followed by a merged full-word write.
//   undefined : SRAM byte enables are driven from data_be_i; every store
//               completes in a single cycle.
// Ports:
//   clk_i, rst_ni                : clock, asynchronous active-low reset
//   data_req_i / data_gnt_o      : request / combinational grant
//   data_rvalid_o / data_err_o   : registered response valid / range error
//   data_addr_i, data_we_i, data_be_i, data_wdata_i : request payload
//   data_rdata_o                 : load data (0 unless in-range load response)
//   sram_req_o, sram_we_o, sram_addr_o, sram_be_o, sram_wdata_o : SRAM command
//   sram_rdata_i                 : SRAM read data, valid the cycle after a read
module data_mem_adapter
    import riscv_cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  data_req_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic                  data_err_o,
    input  logic [31:0]           data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  sram_req_o,
    output logic                  sram_we_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [3:0]            sram_be_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

    // Byte-offset bits are meaningless for word accesses.
    logic unused_addr_bits;
    assign unused_addr_bits = ^data_addr_i[1:0];

    logic                  in_range;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  be_full;
    logic                  be_empty;
    logic                  idle;
    logic                  rmw_start;
    logic                  rmw_wr;

    assign in_range  = ~|data_addr_i[31:ADDR_WIDTH+2];
    assign word_addr = data_addr_i[ADDR_WIDTH+1:2];
    assign be_full   = (data_be_i == 4'hF);
    assign be_empty  = (data_be_i == 4'h0);

`ifdef DATA_MEM_RMW_EN
    dmem_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            be_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] merged;

    dmem_byte_merge u_merge (
        .old_word_i (sram_rdata_i),
        .new_word_i (wdata_q),
        .be_i       (be_q),
        .merged_o   (merged)
    );

    assign idle    = (state_q == DMEM_IDLE);
    assign rmw_wr  = (state_q == DMEM_RMW_WR);
    assign state_d = rmw_start ? DMEM_RMW_WR : DMEM_IDLE;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= DMEM_IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (rmw_start) begin
                addr_q  <= word_addr;
                be_q    <= data_be_i;
                wdata_q <= data_wdata_i;
            end
        end
    end
`else
    assign idle   = 1'b1;
    assign rmw_wr = 1'b0;
`endif

    // Grant depends only on request, reset and registered state, never on
    // sram_rdata_i.
    assign data_gnt_o = data_req_i & rst_ni & idle;

    always_comb begin
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = word_addr;
        sram_be_o    = 4'hF;
        sram_wdata_o = data_wdata_i;
        rmw_start    = 1'b0;
        if (data_gnt_o && in_range) begin
            if (!data_we_i) begin
                sram_req_o = 1'b1;
            end else if (!be_empty) begin
`ifdef DATA_MEM_RMW_EN
                sram_req_o = 1'b1;
                if (be_full) begin
                    sram_we_o = 1'b1;
                end else begin
                    // Read the old word now; write the merge next cycle.
                    rmw_start = 1'b1;
                end
`else
                sram_req_o = 1'b1;
                sram_we_o  = 1'b1;
                sram_be_o  = be_full ? 4'hF : data_be_i;
`endif
            end
        end
`ifdef DATA_MEM_RMW_EN
        if (rmw_wr) begin
            sram_req_o   = 1'b1;
            sram_we_o    = 1'b1;
            sram_addr_o  = addr_q;
            sram_wdata_o = merged;
        end
`endif
    end

    // Response registers. An RMW store responds from its write phase.
    logic rvalid_q, rvalid_d;
    logic err_q, err_d;
    logic resp_is_load_q, resp_is_load_d;

    assign rvalid_d       = (data_gnt_o & ~rmw_start) | rmw_wr;
    assign err_d          = data_gnt_o & ~in_range;
    assign resp_is_load_d = data_gnt_o & ~data_we_i & in_range;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q       <= 1'b0;
            err_q          <= 1'b0;
            resp_is_load_q <= 1'b0;
        end else begin
            rvalid_q       <= rvalid_d;
            err_q          <= err_d;
            resp_is_load_q <= resp_is_load_d;
        end
    end

    assign data_rvalid_o = rvalid_q;
    assign data_err_o    = err_q;
    assign data_rdata_o  = (rvalid_q & resp_is_load_q) ? sram_rdata_i : '0;

endmodule
